fft_result_serializer: RTL and testbench

Output-side companion to the 16-point `FFT` block. It captures each parallel result frame (`fft_d0`..`fft_d15`, qualified by `fft_valid`) into a ping-pong buffer. It then streams the frame out one point per cycle over a valid/ready interface, optionally reordering bit-reversed bins into natural order. It also tracks frames, flags dropped frames, and asserts a drain-complete flag once the FFT's `done` is seen and all captured data has been delivered.

---
 rtl/fft_result_serializer.sv | 230 +++++++++++++++++++++++
 tb/tb_fft_result_serializer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fft_result_serializer
// Purpose  : Ping-pong capture of 16-point FFT result frames, streamed out one
//            point per cycle over valid/ready with optional bit-reversal.
// Revision : 1.0
// ============================================================================
module fft_result_serializer #(
    parameter int DW     = 16,
    parameter int BITREV = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fft_valid,
    input  logic [2*DW-1:0] fft_d0,
    input  logic [2*DW-1:0] fft_d1,
    input  logic [2*DW-1:0] fft_d2,
    input  logic [2*DW-1:0] fft_d3,
    input  logic [2*DW-1:0] fft_d4,
    input  logic [2*DW-1:0] fft_d5,
    input  logic [2*DW-1:0] fft_d6,
    input  logic [2*DW-1:0] fft_d7,
    input  logic [2*DW-1:0] fft_d8,
    input  logic [2*DW-1:0] fft_d9,
    input  logic [2*DW-1:0] fft_d10,
    input  logic [2*DW-1:0] fft_d11,
    input  logic [2*DW-1:0] fft_d12,
    input  logic [2*DW-1:0] fft_d13,
    input  logic [2*DW-1:0] fft_d14,
    input  logic [2*DW-1:0] fft_d15,
    input  logic            done,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [2*DW-1:0] out_data,
    output logic [3:0]      out_idx,
    output logic            out_last,
    output logic [15:0]     frame_cnt,
    output logic [7:0]      drop_cnt,
    output logic            overflow,
    output logic            all_done
);

    localparam logic [3:0] c_LAST_IDX = 4'd15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [2*DW-1:0] w_frame [16];
    logic [2*DW-1:0] r_buf0  [16];
    logic [2*DW-1:0] r_buf1  [16];

    state_t          r_state;
    logic [1:0]      r_full;
    logic            r_wr_sel;
    logic            r_rd_sel;
    logic            r_done_seen;
    logic            r_out_valid;
    logic [2*DW-1:0] r_out_data;
    logic [3:0]      r_rd_idx;
    logic            r_out_last;
    logic [15:0]     r_frame_cnt;
    logic [7:0]      r_drop_cnt;
    logic            r_overflow;
    logic            r_all_done;

    assign w_frame[0]  = fft_d0;
    assign w_frame[1]  = fft_d1;
    assign w_frame[2]  = fft_d2;
    assign w_frame[3]  = fft_d3;
    assign w_frame[4]  = fft_d4;
    assign w_frame[5]  = fft_d5;
    assign w_frame[6]  = fft_d6;
    assign w_frame[7]  = fft_d7;
    assign w_frame[8]  = fft_d8;
    assign w_frame[9]  = fft_d9;
    assign w_frame[10] = fft_d10;
    assign w_frame[11] = fft_d11;
    assign w_frame[12] = fft_d12;
    assign w_frame[13] = fft_d13;
    assign w_frame[14] = fft_d14;
    assign w_frame[15] = fft_d15;

    function automatic logic [3:0] map_idx(input logic [3:0] k);
        if (BITREV != 0) begin
            return {k[0], k[1], k[2], k[3]};
        end
        return k;
    endfunction

    logic w_hs;
    logic w_last_hs;
    logic w_wr_avail;
    logic w_cap;
    logic w_drop;
    logic w_other_full;

    assign w_hs         = r_out_valid & out_ready;
    assign w_last_hs    = w_hs & r_out_last;
    // The buffer being freed by this cycle's final handshake may be refilled now.
    assign w_wr_avail   = ~r_full[r_wr_sel] | (w_last_hs & (r_rd_sel == r_wr_sel));
    assign w_cap        = fft_valid & w_wr_avail;
    assign w_drop       = fft_valid & ~w_wr_avail;
    assign w_other_full = r_full[~r_rd_sel];

    logic            w_load;
    logic            w_load_sel;
    logic            w_go_idle;
    logic [3:0]      w_load_idx;
    logic [3:0]      w_map;
    logic [2*DW-1:0] w_load_word;
    logic [1:0]      w_free;
    logic [1:0]      w_fill;

    always_comb begin
        w_load     = 1'b0;
        w_load_sel = r_rd_sel;
        w_load_idx = 4'd0;
        w_go_idle  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rd_sel]) begin
                    w_load = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_last_hs) begin
                    if (w_other_full) begin
                        w_load     = 1'b1;
                        w_load_sel = ~r_rd_sel;
                    end else begin
                        w_go_idle = 1'b1;
                    end
                end else if (w_hs) begin
                    w_load     = 1'b1;
                    w_load_idx = r_rd_idx + 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign w_map       = map_idx(w_load_idx);
    assign w_load_word = w_load_sel ? r_buf1[w_map] : r_buf0[w_map];

    always_comb begin
        w_free           = 2'b00;
        w_fill           = 2'b00;
        w_free[r_rd_sel] = w_last_hs;
        w_fill[r_wr_sel] = w_cap;
    end

    // Frame storage is deliberately outside reset.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            for (int i = 0; i < 16; i++) begin
                if (r_wr_sel) begin
                    r_buf1[i] <= w_frame[i];
                end else begin
                    r_buf0[i] <= w_frame[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_full      <= 2'b00;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_done_seen <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_rd_idx    <= 4'd0;
            r_out_last  <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_drop_cnt  <= 8'd0;
            r_overflow  <= 1'b0;
            r_all_done  <= 1'b0;
        end else begin
            r_full      <= (r_full & ~w_free) | w_fill;
            r_done_seen <= r_done_seen | done;

            if (w_cap) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_last_hs) begin
                r_rd_sel    <= ~r_rd_sel;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end

            if (w_load) begin
                r_state     <= ST_SEND;
                r_out_valid <= 1'b1;
                r_out_data  <= w_load_word;
                r_rd_idx    <= w_load_idx;
                r_out_last  <= (w_load_idx == c_LAST_IDX);
            end else if (w_go_idle) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
                r_rd_idx    <= 4'd0;
                r_out_last  <= 1'b0;
            end

            if (r_done_seen && (r_full == 2'b00) && (r_state == ST_IDLE)) begin
                r_all_done <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_rd_idx;
    assign out_last  = r_out_last;
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;
    assign all_done  = r_all_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_result_serializer
// Purpose  : Directed bench for fft_result_serializer with a frame-queue model.
// Revision : 1.0
// ============================================================================
module tb_fft_result_serializer;

    localparam int DW = 16;
    typedef logic [16*2*DW-1:0] frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst       = 1'b1;
    logic            fft_valid = 1'b0;
    logic            done      = 1'b0;
    logic            out_ready = 1'b1;
    logic [2*DW-1:0] d [16];

    logic            o0_valid, o0_last, ov0, ad0;
    logic [2*DW-1:0] o0_data;
    logic [3:0]      o0_idx;
    logic [15:0]     fc0;
    logic [7:0]      dc0;
    logic            o1_valid, o1_last, ov1, ad1;
    logic [2*DW-1:0] o1_data;
    logic [3:0]      o1_idx;
    logic [15:0]     fc1;
    logic [7:0]      dc1;

    fft_result_serializer #(.DW(DW), .BITREV(0)) dut0 (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
        .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
        .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
        .done(done), .out_ready(out_ready),
        .out_valid(o0_valid), .out_data(o0_data), .out_idx(o0_idx), .out_last(o0_last),
        .frame_cnt(fc0), .drop_cnt(dc0), .overflow(ov0), .all_done(ad0)
    );

    fft_result_serializer #(.DW(DW), .BITREV(1)) dut1 (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
        .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
        .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
        .done(done), .out_ready(out_ready),
        .out_valid(o1_valid), .out_data(o1_data), .out_idx(o1_idx), .out_last(o1_last),
        .frame_cnt(fc1), .drop_cnt(dc1), .overflow(ov1), .all_done(ad1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input frame_t f, input logic [3:0] k);
        return f[32*k +: 32];
    endfunction

    function automatic logic [3:0] brv(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    function automatic frame_t pack_d();
        frame_t f;
        for (int k = 0; k < 16; k++) f[32*k +: 32] = d[k];
        return f;
    endfunction

    // Model: captured frames wait in a queue of depth two; the head streams out.
    frame_t      fq[$];
    logic        m_valid = 1'b0;
    logic [3:0]  m_idx   = 4'd0;
    logic [15:0] m_fc    = 16'd0;
    logic [7:0]  m_dc    = 8'd0;
    logic        m_ov    = 1'b0;
    logic        m_ad    = 1'b0;
    logic        m_ds    = 1'b0;

    always @(posedge clk) begin : model
        int pre_n;
        bit hs, lst, pre_valid, ad_cond;
        if (rst) begin
            fq.delete();
            m_valid = 1'b0; m_idx = 4'd0; m_fc = 16'd0; m_dc = 8'd0;
            m_ov = 1'b0; m_ad = 1'b0; m_ds = 1'b0;
        end else begin
            pre_n     = fq.size();
            pre_valid = m_valid;
            hs        = m_valid && out_ready;
            lst       = hs && (m_idx == 4'd15);
            ad_cond   = m_ds && (pre_n == 0) && !m_valid;
            if (done) m_ds = 1'b1;
            if (lst) begin
                void'(fq.pop_front());
                m_fc++;
            end
            if (fft_valid) begin
                if (fq.size() < 2) fq.push_back(pack_d());
                else begin
                    m_ov = 1'b1;
                    if (m_dc != 8'd255) m_dc++;
                end
            end
            if (pre_valid) begin
                if (lst) begin
                    m_valid = (pre_n > 1);
                    m_idx   = 4'd0;
                end else if (hs) begin
                    m_idx++;
                end
            end else if (pre_n > 0) begin
                m_valid = 1'b1;
                m_idx   = 4'd0;
            end
            if (ad_cond) m_ad = 1'b1;
        end
    end

    int rmode = 0;
    int rpos  = 0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    always @(negedge clk) begin
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: begin
                out_ready = pat[rpos % 6];
                rpos++;
            end
        endcase
    end

    bit              chk_en = 1'b0;
    int              cyc = 0;
    int              first_hs = 0;
    int              last_hs = 0;
    logic [31:0]     q0[$];
    logic [31:0]     q1[$];
    bit              prev_stall = 1'b0;
    logic [2*DW-1:0] prev_data = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : compare
        #1;
        if (chk_en) begin
            chk("out_valid", o0_valid, m_valid);
            chk("out_valid_br", o1_valid, m_valid);
            if (m_valid && fq.size() > 0) begin
                chk("out_data", o0_data, word(fq[0], m_idx));
                chk("out_data_br", o1_data, word(fq[0], brv(m_idx)));
                chk("out_idx", o0_idx, m_idx);
                chk("out_idx_br", o1_idx, m_idx);
                chk("out_last", o0_last, m_idx == 4'd15);
                chk("out_last_br", o1_last, m_idx == 4'd15);
            end
            if (prev_stall && o0_valid) chk("stall_hold", o0_data, prev_data);
            chk("frame_cnt", fc0, m_fc);
            chk("frame_cnt_br", fc1, m_fc);
            chk("drop_cnt", dc0, m_dc);
            chk("drop_cnt_br", dc1, m_dc);
            chk("overflow", ov0, m_ov);
            chk("overflow_br", ov1, m_ov);
            chk("all_done", ad0, m_ad);
            chk("all_done_br", ad1, m_ad);
            if (o0_valid && out_ready) begin
                if (q0.size() == 0) first_hs = cyc;
                last_hs = cyc;
                q0.push_back(o0_data);
            end
            if (o1_valid && out_ready) q1.push_back(o1_data);
            prev_stall = o0_valid && !out_ready;
            prev_data  = o0_data;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input frame_t f);
        for (int k = 0; k < 16; k++) d[k] = f[32*k +: 32];
        fft_valid = 1'b1;
        @(negedge clk);
        fft_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fq.size() == 0 && !m_valid && !o0_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", ok, 1'b1);
    endtask

    function automatic frame_t mk_s1();
        frame_t f;
        for (int k = 0; k < 16; k++) f[32*k +: 32] = {16'(k), 16'h8000 + 16'(k)};
        return f;
    endfunction

    function automatic frame_t mk_id(input int n);
        frame_t f;
        for (int k = 0; k < 16; k++) f[32*k +: 32] = {8'(n), 8'(k), 16'(n * 16 + k)};
        return f;
    endfunction

    function automatic frame_t mk_k();
        frame_t f;
        for (int k = 0; k < 16; k++) f[32*k +: 32] = 32'(k);
        return f;
    endfunction

    int exp_br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    initial begin
        bit hit;
        for (int k = 0; k < 16; k++) d[k] = '0;
        repeat (2) tick();
        chk_en = 1'b1;
        chk("rst_valid", o0_valid, 1'b0);
        chk("rst_data", o0_data, 32'h0);
        chk("rst_frame_cnt", fc0, 16'h0);
        tick();
        rst = 1'b0;

        // Single frame, ready held high
        q0.delete();
        send(mk_s1());
        drain(60);
        chk("s1_words", q0.size(), 16);
        chk("s1_first", q0[0], 32'h0000_8000);
        chk("s1_last", q0[15], 32'h000F_800F);
        chk("s1_frame_cnt", fc0, 16'd1);

        // Same frame under the 1,0,0,1,0,1 ready pattern
        q0.delete();
        rpos  = 0;
        rmode = 2;
        send(mk_s1());
        drain(120);
        rmode = 0;
        chk("bp_words", q0.size(), 16);
        chk("bp_word7", q0[7], 32'h0007_8007);
        chk("bp_frame_cnt", fc0, 16'd2);

        // Four frames every 16 cycles
        tick();
        q0.delete();
        for (int f = 0; f < 4; f++) begin
            send(mk_id(f + 1));
            if (f < 3) repeat (15) tick();
        end
        drain(100);
        chk("b2b_words", q0.size(), 64);
        chk("b2b_no_gap", last_hs - first_hs, 63);
        chk("b2b_w16", q0[16], 32'h0200_0020);
        chk("b2b_frame_cnt", fc0, 16'd6);
        chk("b2b_overflow", ov0, 1'b0);

        // Third capture lands on the edge that frees the first buffer
        q0.delete();
        send(mk_id(20));
        send(mk_id(21));
        repeat (15) tick();
        send(mk_id(22));
        drain(100);
        chk("free_cap_words", q0.size(), 48);
        chk("free_cap_no_gap", last_hs - first_hs, 47);
        chk("free_cap_drop", dc0, 8'd0);
        chk("free_cap_frame_cnt", fc0, 16'd9);

        // Overflow: two retained, third dropped
        rmode = 1;
        tick();
        q0.delete();
        send(mk_id(10));
        tick();
        send(mk_id(11));
        tick();
        send(mk_id(12));
        tick();
        chk("ovf_drop_cnt", dc0, 8'd1);
        chk("ovf_flag", ov0, 1'b1);
        rmode = 0;
        drain(100);
        chk("ovf_words", q0.size(), 32);
        chk("ovf_w0", q0[0], 32'h0A00_00A0);
        chk("ovf_w16", q0[16], 32'h0B00_00B0);
        chk("ovf_frame_cnt", fc0, 16'd11);

        // Bit-reversed ordering on the BITREV=1 instance
        q1.delete();
        send(mk_k());
        drain(60);
        chk("br_words", q1.size(), 16);
        for (int i = 0; i < 16; i++) chk("br_seq", q1[i], 32'(exp_br[i]));

        // Reset mid-frame at out_idx 7
        send(mk_s1());
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o0_valid && o0_idx == 4'd7) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_reach_idx7", hit, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_valid", o0_valid, 1'b0);
        chk("midrst_data", o0_data, 32'h0);
        chk("midrst_idx", o0_idx, 4'd0);
        chk("midrst_last", o0_last, 1'b0);
        chk("midrst_frame_cnt", fc0, 16'd0);
        rst = 1'b0;
        q0.delete();
        send(mk_id(5));
        drain(60);
        chk("post_rst_words", q0.size(), 16);
        chk("post_rst_w0", q0[0], 32'h0500_0050);
        chk("post_rst_frame_cnt", fc0, 16'd1);

        // done pulsed with one frame pending
        rmode = 1;
        tick();
        send(mk_id(6));
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (5) tick();
        chk("done_pending", ad0, 1'b0);
        rmode = 0;
        drain(60);
        chk("done_at_drain", ad0, 1'b0);
        repeat (2) tick();
        chk("done_rise", ad0, 1'b1);
        repeat (4) tick();
        chk("done_sticky", ad0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
